powerup_ctrl: RTL and testbench

POWERUP_CTRL -- requirements
Module: powerup_ctrl

---
 rtl/pong_pkg.sv | 42 ++++
 rtl/pu_timer.sv | 27 ++
 rtl/powerup_ctrl.sv | 175 +++++++++++++++++
 tb/tb_powerup_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong constants, screen geometry and powerup encodings.
// Also holds the spawn-row clamp used when a powerup box appears.
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BOX      = 16;
  localparam int BALL     = 8;

  localparam logic [7:0] PAD_H_NORM  = 8'd64;
  localparam logic [7:0] PAD_H_BIG   = 8'd96;
  localparam logic [7:0] PAD_H_SMALL = 8'd32;

  // Box column sits in the middle of the court, clear of both paddles.
  localparam logic [9:0] POWER_X = 10'd312;

  localparam logic [8:0] Y_MIN  = 9'd16;
  localparam logic [8:0] Y_MAX  = 9'd448;
  localparam logic [8:0] Y_WRAP = 9'd64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPAWNED = 2'd1,
    ST_ACTIVE  = 2'd2
  } pu_state_t;

  typedef enum logic {
    PU_GROW   = 1'b0,
    PU_SHRINK = 1'b1
  } pu_type_t;

  // Keeps the box fully on screen for any 9-bit random row.
  function automatic logic [8:0] spawn_y(input logic [8:0] rp);
    if (rp < Y_MIN)
      return Y_MIN;
    else if (rp > Y_MAX)
      return rp - Y_WRAP;
    else
      return rp;
  endfunction

endpackage

// File: rtl/pu_timer.sv
// Loadable 10-bit down-counter with tick enable and zero flag.
// One instance times the spawn delay, box lifetime and effect duration.
module pu_timer #(
  parameter logic [9:0] RESET_VAL = 10'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [9:0] load_val,
  input  logic       tick,
  output logic       zero
);

  logic [9:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= RESET_VAL;
    else if (load)
      count <= load_val;
    else if (tick && count != 10'd0)
      count <= count - 10'd1;
  end

  assign zero = (count == 10'd0);

endmodule

// File: rtl/powerup_ctrl.sv
// Powerup controller: waits, spawns a box, detects the ball collecting it,
// then applies a timed paddle-height effect to one side.
module powerup_ctrl
  import pong_pkg::*;
#(
  parameter int SPAWN_TICKS  = 600,
  parameter int LIFE_TICKS   = 300,
  parameter int EFFECT_TICKS = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_en,
  input  logic       round_end,
  input  logic [9:0] x_ball,
  input  logic [9:0] y_ball,
  input  logic       ball_dx,
  input  logic [8:0] rand_pos,
  input  logic [1:0] rand_type,
  output logic       power_en,
  output logic [9:0] power_pos_x,
  output logic [8:0] power_pos_y,
  output logic       powerA,
  output logic       powerB,
  output logic [7:0] padA_h,
  output logic [7:0] padB_h
);

  localparam logic [9:0] SPAWN_LOAD  = 10'(SPAWN_TICKS - 1);
  localparam logic [9:0] LIFE_LOAD   = 10'(LIFE_TICKS - 1);
  localparam logic [9:0] EFFECT_LOAD = 10'(EFFECT_TICKS - 1);

  pu_state_t  state, state_next;
  pu_type_t   type_sel, type_next;
  logic       en_next, a_next, b_next;
  logic [8:0] y_next;
  logic [7:0] pa_next, pb_next;

  logic       t_load, t_tick, t_zero;
  logic [9:0] t_val;
  logic       hit;

  // Only bit 0 selects the effect; bit 1 is deliberately ignored.
  logic unused_type_bit;
  assign unused_type_bit = rand_type[1];

  pu_timer #(.RESET_VAL(SPAWN_LOAD)) timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .tick     (t_tick),
    .zero     (t_zero)
  );

  // Bounding-box overlap in 11 bits so x+8 / y+16 cannot wrap.
  always_comb begin
    hit = ({1'b0, x_ball} + 11'(BALL) > {1'b0, power_pos_x}) &&
          ({1'b0, x_ball} < {1'b0, power_pos_x} + 11'(BOX)) &&
          ({1'b0, y_ball} + 11'(BALL) > {2'b00, power_pos_y}) &&
          ({1'b0, y_ball} < {2'b00, power_pos_y} + 11'(BOX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      type_sel    <= PU_GROW;
      power_en    <= 1'b0;
      power_pos_x <= POWER_X;
      power_pos_y <= 9'd0;
      powerA      <= 1'b0;
      powerB      <= 1'b0;
      padA_h      <= PAD_H_NORM;
      padB_h      <= PAD_H_NORM;
    end else begin
      state       <= state_next;
      type_sel    <= type_next;
      power_en    <= en_next;
      power_pos_x <= POWER_X;
      power_pos_y <= y_next;
      powerA      <= a_next;
      powerB      <= b_next;
      padA_h      <= pa_next;
      padB_h      <= pb_next;
    end
  end

  always_comb begin
    state_next = state;
    type_next  = type_sel;
    en_next    = power_en;
    y_next     = power_pos_y;
    a_next     = powerA;
    b_next     = powerB;
    pa_next    = padA_h;
    pb_next    = padB_h;
    t_load     = 1'b0;
    t_val      = SPAWN_LOAD;
    t_tick     = 1'b0;

    if (round_end) begin
      state_next = ST_IDLE;
      en_next    = 1'b0;
      a_next     = 1'b0;
      b_next     = 1'b0;
      pa_next    = PAD_H_NORM;
      pb_next    = PAD_H_NORM;
      t_load     = 1'b1;
      t_val      = SPAWN_LOAD;
    end else if (game_en) begin
      case (state)
        ST_IDLE: begin
          if (t_zero) begin
            state_next = ST_SPAWNED;
            en_next    = 1'b1;
            y_next     = spawn_y(rand_pos);
            type_next  = pu_type_t'(rand_type[0]);
            t_load     = 1'b1;
            t_val      = LIFE_LOAD;
          end else begin
            t_tick = 1'b1;
          end
        end

        ST_SPAWNED: begin
          // Collection beats expiry when both land on the same tick.
          if (hit) begin
            state_next = ST_ACTIVE;
            en_next    = 1'b0;
            a_next     = ball_dx;
            b_next     = !ball_dx;
            pa_next    = PAD_H_NORM;
            pb_next    = PAD_H_NORM;
            if (type_sel == PU_GROW) begin
              if (ball_dx) pa_next = PAD_H_BIG;
              else         pb_next = PAD_H_BIG;
            end else begin
              if (ball_dx) pb_next = PAD_H_SMALL;
              else         pa_next = PAD_H_SMALL;
            end
            t_load = 1'b1;
            t_val  = EFFECT_LOAD;
          end else if (t_zero) begin
            state_next = ST_IDLE;
            en_next    = 1'b0;
            t_load     = 1'b1;
            t_val      = SPAWN_LOAD;
          end else begin
            t_tick = 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (t_zero) begin
            state_next = ST_IDLE;
            a_next     = 1'b0;
            b_next     = 1'b0;
            pa_next    = PAD_H_NORM;
            pb_next    = PAD_H_NORM;
            t_load     = 1'b1;
            t_val      = SPAWN_LOAD;
          end else begin
            t_tick = 1'b1;
          end
        end

        default: begin
          state_next = ST_IDLE;
          t_load     = 1'b1;
          t_val      = SPAWN_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_powerup_ctrl.sv
// Directed bench for powerup_ctrl: a tick-counting reference model checked
// every cycle, plus literal expectations at the key scenario points.
module tb_powerup_ctrl;

  localparam int SP = 4;
  localparam int LF = 6;
  localparam int EF = 5;

  localparam int PH_WAIT   = 0;
  localparam int PH_SHOW   = 1;
  localparam int PH_EFFECT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_en = 1'b0;
  logic       round_end = 1'b0;
  logic [9:0] x_ball = 10'd0;
  logic [9:0] y_ball = 10'd0;
  logic       ball_dx = 1'b1;
  logic [8:0] rand_pos = 9'd0;
  logic [1:0] rand_type = 2'd0;

  logic       power_en;
  logic [9:0] power_pos_x;
  logic [8:0] power_pos_y;
  logic       powerA, powerB;
  logic [7:0] padA_h, padB_h;

  powerup_ctrl #(.SPAWN_TICKS(SP), .LIFE_TICKS(LF), .EFFECT_TICKS(EF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_en     (game_en),
    .round_end   (round_end),
    .x_ball      (x_ball),
    .y_ball      (y_ball),
    .ball_dx     (ball_dx),
    .rand_pos    (rand_pos),
    .rand_type   (rand_type),
    .power_en    (power_en),
    .power_pos_x (power_pos_x),
    .power_pos_y (power_pos_y),
    .powerA      (powerA),
    .powerB      (powerB),
    .padA_h      (padA_h),
    .padB_h      (padB_h)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Reference: counts ticks spent in the current phase and compares with the
  // configured durations; outputs follow the effect rules directly.
  typedef struct {
    int ph;
    int n;
    bit shrink;
    int en, y, a, b, pa, pb;
  } model_t;

  model_t m = '{ph: PH_WAIT, n: 0, shrink: 1'b0, en: 0, y: 0, a: 0, b: 0, pa: 64, pb: 64};

  function automatic int clamp_y(int rp);
    if (rp < 16) return 16;
    if (rp > 448) return rp - 64;
    return rp;
  endfunction

  function automatic model_t idle_of(model_t c);
    model_t r = c;
    r.ph = PH_WAIT; r.n = 0; r.en = 0; r.a = 0; r.b = 0; r.pa = 64; r.pb = 64;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, bit rn, bit re, bit ge,
                                        int xb, int yb, bit dx, int rp, bit rt0);
    model_t r = c;
    if (!rn) begin
      r = idle_of(c);
      r.y = 0;
      r.shrink = 1'b0;
    end else if (re) begin
      r = idle_of(c);
    end else if (ge) begin
      if (c.ph == PH_WAIT) begin
        r.n = c.n + 1;
        if (r.n == SP) begin
          r.ph = PH_SHOW; r.n = 0; r.en = 1; r.y = clamp_y(rp); r.shrink = rt0;
        end
      end else if (c.ph == PH_SHOW) begin
        if (xb + 8 > 312 && xb < 328 && yb + 8 > c.y && yb < c.y + 16) begin
          r.ph = PH_EFFECT; r.n = 0; r.en = 0;
          r.a = dx ? 1 : 0;
          r.b = dx ? 0 : 1;
          r.pa = 64; r.pb = 64;
          if (!c.shrink) begin
            if (dx) r.pa = 96; else r.pb = 96;
          end else begin
            if (dx) r.pb = 32; else r.pa = 32;
          end
        end else begin
          r.n = c.n + 1;
          if (r.n == LF) begin
            r.ph = PH_WAIT; r.n = 0; r.en = 0;
          end
        end
      end else begin
        r.n = c.n + 1;
        if (r.n == EF) r = idle_of(c);
      end
    end
    return r;
  endfunction

  always @(posedge clk)
    m <= model_step(m, rst_n, round_end, game_en, int'(x_ball), int'(y_ball),
                    ball_dx, int'(rand_pos), rand_type[0]);

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("power_en",    int'(power_en),    m.en);
      check("power_pos_x", int'(power_pos_x), 312);
      check("power_pos_y", int'(power_pos_y), m.y);
      check("powerA",      int'(powerA),      m.a);
      check("powerB",      int'(powerB),      m.b);
      check("padA_h",      int'(padA_h),      m.pa);
      check("padB_h",      int'(padB_h),      m.pb);
    end
  end

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic reset_vals(string tag);
    check({tag, ".en"}, int'(power_en), 0);
    check({tag, ".x"},  int'(power_pos_x), 312);
    check({tag, ".y"},  int'(power_pos_y), 0);
    check({tag, ".a"},  int'(powerA), 0);
    check({tag, ".b"},  int'(powerB), 0);
    check({tag, ".pa"}, int'(padA_h), 64);
    check({tag, ".pb"}, int'(padB_h), 64);
  endtask

  initial begin
    cyc(2);
    chk_on = 1'b1;
    reset_vals("reset");
    $display("txn: reset released");
    rst_n = 1'b1;
    game_en = 1'b1;
    rand_pos = 9'd200;
    rand_type = 2'b00;

    cyc(3);
    check("pre_spawn.en", int'(power_en), 0);
    cyc(1);
    check("spawn200.en", int'(power_en), 1);
    check("spawn200.y", int'(power_pos_y), 200);
    check("spawn200.x", int'(power_pos_x), 312);
    $display("txn: spawn at y=%0d", power_pos_y);

    x_ball = 10'd310; y_ball = 10'd204; ball_dx = 1'b1;
    cyc(1);
    check("growA.en", int'(power_en), 0);
    check("growA.a", int'(powerA), 1);
    check("growA.pa", int'(padA_h), 96);
    check("growA.pb", int'(padB_h), 64);
    $display("txn: A collected GROW, padA_h=%0d", padA_h);
    x_ball = 10'd0; y_ball = 10'd0;
    cyc(EF - 1);
    check("growA_hold.a", int'(powerA), 1);
    cyc(1);
    check("growA_end.a", int'(powerA), 0);
    check("growA_end.pa", int'(padA_h), 64);
    $display("txn: GROW effect expired");

    rand_pos = 9'd10;
    cyc(SP);
    check("spawn10.y", int'(power_pos_y), 16);
    cyc(LF - 1);
    check("life_last.en", int'(power_en), 1);
    cyc(1);
    check("life_exp.en", int'(power_en), 0);
    $display("txn: rand_pos=10 spawned at 16 then expired");

    rand_pos = 9'd500;
    cyc(SP);
    check("spawn500.y", int'(power_pos_y), 436);
    cyc(LF);
    $display("txn: rand_pos=500 spawned at %0d", 436);

    rand_pos = 9'd448;
    rand_type = 2'b01;
    cyc(SP);
    check("spawn448.y", int'(power_pos_y), 448);
    cyc(LF - 1);
    x_ball = 10'd320; y_ball = 10'd450; ball_dx = 1'b0;
    cyc(1);
    check("shrinkB.en", int'(power_en), 0);
    check("shrinkB.b", int'(powerB), 1);
    check("shrinkB.a", int'(powerA), 0);
    check("shrinkB.pa", int'(padA_h), 32);
    check("shrinkB.pb", int'(padB_h), 64);
    $display("txn: B collected SHRINK on expiry tick");
    x_ball = 10'd0; y_ball = 10'd0;

    game_en = 1'b0;
    cyc(100);
    check("pause.b", int'(powerB), 1);
    check("pause.pa", int'(padA_h), 32);
    $display("txn: 100-cycle pause held effect");
    game_en = 1'b1;
    cyc(2);
    check("pre_re.b", int'(powerB), 1);
    round_end = 1'b1;
    cyc(1);
    round_end = 1'b0;
    check("round_end.b", int'(powerB), 0);
    check("round_end.pa", int'(padA_h), 64);
    $display("txn: round_end cleared effect");

    rand_pos = 9'd100;
    round_end = 1'b1;
    cyc(10);
    round_end = 1'b0;
    cyc(SP - 1);
    check("re_hold.en", int'(power_en), 0);
    cyc(1);
    check("re_hold_spawn.en", int'(power_en), 1);
    $display("txn: held round_end kept spawn timer full");

    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    reset_vals("midreset");
    $display("txn: reset during SPAWNED");

    rand_pos = 9'd300;
    rand_type = 2'b10;
    y_ball = 10'd302;
    for (int i = 0; i < 120; i++) begin
      game_en = (i % 3) != 0;
      x_ball = 10'(260 + (i % 80));
      ball_dx = i[2];
      round_end = (i == 100);
      cyc(1);
    end
    round_end = 1'b0;
    $display("txn: mixed sweep done");

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
